// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle RV32I control sequencer sharing one memory port between fetch and load/store.
// Define CTRL_PERF_EN to build the perf_cycles/perf_instret counters; otherwise both ports read 0.
module mc_ctrl_fsm #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_src_a,
    output logic        alu_src_b,
    output logic [2:0]  imm_type,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        retire,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] perf_cycles,
    output logic [31:0] perf_instret
);
    localparam int unsigned TO_W = 16;

    localparam logic [2:0] IMM_I = 3'd1;
    localparam logic [2:0] IMM_S = 3'd2;
    localparam logic [2:0] IMM_B = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;
    localparam logic [2:0] IMM_U = 3'd5;
    localparam logic [1:0] PC_IMM = 2'd1;
    localparam logic [1:0] PC_ALU = 2'd2;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] A_PC   = 2'd1;
    localparam logic [1:0] A_ZERO = 2'd2;
    localparam logic [1:0] CAUSE_ILL = 2'd1;
    localparam logic [1:0] CAUSE_TO  = 2'd2;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_e;
    typedef enum logic [3:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILL
    } class_e;

    state_e          state_q, state_d;
    class_e          cls_q, cls_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            trap_q, trap_d;
    logic [1:0]      cause_q, cause_d;
    logic            mem_wait;

    function automatic class_e decode_op(input logic [6:0] op);
        case (op)
            7'h33:   return C_R;
            7'h13:   return C_I;
            7'h03:   return C_LOAD;
            7'h23:   return C_STORE;
            7'h63:   return C_BRANCH;
            7'h6F:   return C_JAL;
            7'h67:   return C_JALR;
            7'h37:   return C_LUI;
            7'h17:   return C_AUIPC;
            default: return C_ILL;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            cls_q    <= C_R;
            to_cnt_q <= '0;
            trap_q   <= 1'b0;
            cause_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            cls_q    <= cls_d;
            to_cnt_q <= to_cnt_d;
            trap_q   <= trap_d;
            cause_q  <= cause_d;
        end
    end

    // Next state and strobes; strobes depend on state, registered class and mem_ready.
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        to_cnt_d  = '0;
        trap_d    = trap_q;
        cause_d   = cause_q;
        mem_wait  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_sel   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 2'd0;
        alu_src_a = 2'd0;
        alu_src_b = 1'b0;
        imm_type  = 3'd0;
        reg_we    = 1'b0;
        wb_sel    = 2'd0;
        retire    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    mem_wait = 1'b1;
                end
            end
            S_DECODE: begin
                cls_d = decode_op(opcode);
                if (cls_d == C_ILL) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_ILL;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls_q)
                    C_BRANCH: begin
                        pc_we   = 1'b1;
                        pc_src  = branch_taken ? PC_IMM : 2'd0;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    C_LOAD, C_STORE: state_d = S_MEM;
                    default:         state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_sel = 1'b1;
                mem_we  = (cls_q == C_STORE);
                if (mem_ready) begin
                    if (cls_q == C_STORE) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else begin
                    mem_wait = 1'b1;
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
                case (cls_q)
                    C_LOAD:  wb_sel = WB_MEM;
                    C_JAL:   begin wb_sel = WB_PC4; pc_src = PC_IMM; end
                    C_JALR:  begin wb_sel = WB_PC4; pc_src = PC_ALU; end
                    default: ;
                endcase
            end
            S_TRAP:  ;
            default: state_d = S_FETCH;
        endcase

        // A ready arriving in the limit cycle still completes the access.
        if (mem_wait) begin
            if (to_cnt_q == TO_W'(MEM_TIMEOUT)) begin
                state_d = S_TRAP;
                trap_d  = 1'b1;
                cause_d = CAUSE_TO;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end

        if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
            case (cls_q)
                C_I, C_LOAD, C_JALR: begin imm_type = IMM_I; alu_src_b = 1'b1; end
                C_STORE:  begin imm_type = IMM_S; alu_src_b = 1'b1; end
                C_BRANCH: imm_type = IMM_B;
                C_JAL:    imm_type = IMM_J;
                C_LUI:    begin imm_type = IMM_U; alu_src_a = A_ZERO; alu_src_b = 1'b1; end
                C_AUIPC:  begin imm_type = IMM_U; alu_src_a = A_PC; alu_src_b = 1'b1; end
                default:  ;
            endcase
        end

        // Reset silences every strobe and select at once, even mid-transaction.
        if (!rst_n) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_sel   = 1'b0;
            ir_we     = 1'b0;
            pc_we     = 1'b0;
            pc_src    = 2'd0;
            alu_src_a = 2'd0;
            alu_src_b = 1'b0;
            imm_type  = 3'd0;
            reg_we    = 1'b0;
            wb_sel    = 2'd0;
            retire    = 1'b0;
        end
    end

    assign trap       = trap_q;
    assign trap_cause = cause_q;

`ifdef CTRL_PERF_EN
    localparam int unsigned PERF_W = 32;

    logic [PERF_W-1:0] perf_cycles_q, perf_cycles_d;
    logic [PERF_W-1:0] perf_instret_q, perf_instret_d;

    always_comb begin
        perf_cycles_d  = perf_cycles_q + PERF_W'(1);
        perf_instret_d = perf_instret_q + PERF_W'(retire);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles_q  <= '0;
            perf_instret_q <= '0;
        end else begin
            perf_cycles_q  <= perf_cycles_d;
            perf_instret_q <= perf_instret_d;
        end
    end

    assign perf_cycles  = perf_cycles_q;
    assign perf_instret = perf_instret_q;
`else
    assign perf_cycles  = '0;
    assign perf_instret = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed and random instruction streams checked cycle by cycle
// against a per-instruction phase model built from each opcode's class attributes.
module tb_mc_ctrl_fsm;
    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        mem_ready;
    logic        mem_req, mem_we, mem_sel, ir_we, pc_we;
    logic [1:0]  pc_src, alu_src_a;
    logic        alu_src_b;
    logic [2:0]  imm_type;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        retire, trap;
    logic [1:0]  trap_cause;
    logic [31:0] perf_cycles, perf_instret;

    mc_ctrl_fsm #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_type(imm_type), .reg_we(reg_we), .wb_sel(wb_sel),
        .retire(retire), .trap(trap), .trap_cause(trap_cause),
        .perf_cycles(perf_cycles), .perf_instret(perf_instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, mem_we, mem_sel, ir_we, pc_we;
        logic [1:0] pc_src;
        logic [1:0] alu_src_a;
        logic       alu_src_b;
        logic [2:0] imm_type;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       retire, trap;
        logic [1:0] trap_cause;
    } outs_t;

    typedef enum {K_ALU, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_JALR, K_ILL} kind_e;

    outs_t obs;
    assign obs = {mem_req, mem_we, mem_sel, ir_we, pc_we, pc_src, alu_src_a, alu_src_b,
                  imm_type, reg_we, wb_sel, retire, trap, trap_cause};

    int          n_checks = 0;
    int          n_pass   = 0;
    int unsigned model_cyc = 0;
    int unsigned model_ret = 0;
    logic [6:0]  legal_ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] pk(input outs_t o);
        pk = '0;
        pk[$bits(outs_t)-1:0] = o;
    endfunction

    // Class attributes straight from the ISA control table.
    function automatic void classify(input logic [6:0] op, output kind_e k,
                                     output logic [2:0] imm, output logic [1:0] a, output logic b);
        k = K_ILL; imm = 3'd0; a = 2'd0; b = 1'b0;
        case (op)
            7'h33: k = K_ALU;
            7'h13: begin k = K_ALU;    imm = 3'd1; b = 1'b1; end
            7'h03: begin k = K_LOAD;   imm = 3'd1; b = 1'b1; end
            7'h23: begin k = K_STORE;  imm = 3'd2; b = 1'b1; end
            7'h63: begin k = K_BRANCH; imm = 3'd3; end
            7'h6F: begin k = K_JAL;    imm = 3'd4; end
            7'h67: begin k = K_JALR;   imm = 3'd1; b = 1'b1; end
            7'h37: begin k = K_ALU;    imm = 3'd5; a = 2'd2; b = 1'b1; end
            7'h17: begin k = K_ALU;    imm = 3'd5; a = 2'd1; b = 1'b1; end
            default: ;
        endcase
    endfunction

    // One clock: drive inputs (already at posedge+1), check at negedge, advance.
    task automatic step(input string tag, input outs_t exp, input logic rdy,
                        input logic [6:0] op, input logic bt);
        opcode = op; branch_taken = bt; mem_ready = rdy;
        @(negedge clk);
        chk(tag, pk(obs), pk(exp));
        @(posedge clk); #1;
        model_cyc++;
        if (exp.retire) model_ret++;
    endtask

    task automatic trap_cycles(input string nm, input logic [1:0] cause, input int n);
        outs_t e;
        for (int i = 0; i < n; i++) begin
            e = '0; e.trap = 1'b1; e.trap_cause = cause;
            step({nm, ".TRAP"}, e, 1'($urandom), 7'($urandom), 1'($urandom));
        end
    endtask

    task automatic chk_perf(input string nm);
`ifdef CTRL_PERF_EN
        chk({nm, ".cycles"},  perf_cycles,  model_cyc);
        chk({nm, ".instret"}, perf_instret, model_ret);
`else
        chk({nm, ".cycles"},  perf_cycles,  32'd0);
        chk({nm, ".instret"}, perf_instret, 32'd0);
`endif
    endtask

    task automatic do_reset(input string nm);
        rst_n = 1'b0; mem_ready = 1'($urandom); opcode = 7'($urandom);
        @(negedge clk);
        chk({nm, ".outs"}, pk(obs), 32'd0);
        chk({nm, ".pcyc"}, perf_cycles, 32'd0);
        chk({nm, ".pret"}, perf_instret, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; model_cyc = 0; model_ret = 0;
    endtask

    // Full instruction: fw/mw are the number of wait cycles before mem_ready in FETCH/MEM.
    task automatic run_instr(input string nm, input logic [6:0] op, input logic bt,
                             input int fw, input int mw);
        kind_e k; logic [2:0] imm; logic [1:0] a; logic b; outs_t e, s;
        classify(op, k, imm, a, b);
        for (int i = 0; i <= fw; i++) begin
            e = '0; e.mem_req = 1'b1; e.ir_we = (i == fw);
            step({nm, ".FETCH"}, e, (i == fw), 7'($urandom), 1'($urandom));
        end
        e = '0;
        step({nm, ".DECODE"}, e, 1'($urandom), op, 1'($urandom));
        if (k == K_ILL) begin
            trap_cycles(nm, 2'd1, 3);
            return;
        end
        s = '0; s.imm_type = imm; s.alu_src_a = a; s.alu_src_b = b;
        e = s;
        if (k == K_BRANCH) begin
            e.pc_we = 1'b1; e.pc_src = bt ? 2'd1 : 2'd0; e.retire = 1'b1;
        end
        step({nm, ".EXEC"}, e, 1'($urandom), op, bt);
        if (k == K_BRANCH) return;
        if (k == K_LOAD || k == K_STORE) begin
            for (int i = 0; i <= mw; i++) begin
                e = s; e.mem_req = 1'b1; e.mem_sel = 1'b1; e.mem_we = (k == K_STORE);
                if (i == mw && k == K_STORE) begin e.pc_we = 1'b1; e.retire = 1'b1; end
                step({nm, ".MEM"}, e, (i == mw), op, 1'($urandom));
            end
            if (k == K_STORE) return;
        end
        e = s; e.reg_we = 1'b1; e.pc_we = 1'b1; e.retire = 1'b1;
        e.wb_sel = (k == K_LOAD) ? 2'd1 : (k == K_JAL || k == K_JALR) ? 2'd2 : 2'd0;
        e.pc_src = (k == K_JAL) ? 2'd1 : (k == K_JALR) ? 2'd2 : 2'd0;
        step({nm, ".WB"}, e, 1'($urandom), op, 1'($urandom));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        outs_t e, s;
        int fw, mw;
        rst_n = 1'b0; opcode = 7'd0; branch_taken = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        do_reset("RESET");

        run_instr("ADDI", 7'h13, 1'b0, 0, 0);
        run_instr("LW",   7'h03, 1'b0, 0, 3);
        run_instr("BEQ1", 7'h63, 1'b1, 0, 0);
        run_instr("BEQ0", 7'h63, 1'b0, 0, 0);
        run_instr("JALR", 7'h67, 1'b0, 0, 0);
        run_instr("SW",   7'h23, 1'b0, 0, 0);
        run_instr("JAL",  7'h6F, 1'b0, 1, 0);
        run_instr("LUI",  7'h37, 1'b0, 0, 0);
        run_instr("AUIPC", 7'h17, 1'b0, 0, 0);
        run_instr("FWMAX", 7'h33, 1'b0, TO, 0);
        run_instr("MWMAX", 7'h23, 1'b0, 0, TO);
        chk_perf("DIR");

        for (int n = 0; n < 60; n++) begin
            fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO)) : 0;
            mw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, TO)) : 0;
            run_instr($sformatf("R%0d", n), legal_ops[$urandom_range(0, 8)], 1'($urandom), fw, mw);
        end
        chk_perf("RAND");

        // Load interrupted by reset while waiting in MEM.
        e = '0; e.mem_req = 1'b1; e.ir_we = 1'b1;
        step("RSTMID.FETCH", e, 1'b1, 7'h00, 1'b0);
        e = '0;
        step("RSTMID.DECODE", e, 1'b0, 7'h03, 1'b0);
        s = '0; s.imm_type = 3'd1; s.alu_src_b = 1'b1;
        step("RSTMID.EXEC", s, 1'b0, 7'h03, 1'b0);
        mem_ready = 1'b0; #1;
        e = s; e.mem_req = 1'b1; e.mem_sel = 1'b1;
        chk("RSTMID.MEM", pk(obs), pk(e));
        #1; rst_n = 1'b0; #1;
        chk("RSTMID.reset", pk(obs), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; model_cyc = 0; model_ret = 0;

        for (int n = 0; n < 10; n++) run_instr("ADDI10", 7'h13, 1'b0, 0, 0);
        chk_perf("ADDI10");

        run_instr("ILL", 7'h7F, 1'b0, 0, 0);
        chk_perf("ILL");
        do_reset("RST2");

        for (int i = 0; i <= int'(TO); i++) begin
            e = '0; e.mem_req = 1'b1;
            step("FTO.FETCH", e, 1'b0, 7'($urandom), 1'($urandom));
        end
        trap_cycles("FTO", 2'd2, 3);
        chk_perf("FTO");
        do_reset("RST3");

        e = '0; e.mem_req = 1'b1; e.ir_we = 1'b1;
        step("MTO.FETCH", e, 1'b1, 7'h00, 1'b0);
        e = '0;
        step("MTO.DECODE", e, 1'b0, 7'h23, 1'b0);
        s = '0; s.imm_type = 3'd2; s.alu_src_b = 1'b1;
        step("MTO.EXEC", s, 1'b0, 7'h23, 1'b0);
        for (int i = 0; i <= int'(TO); i++) begin
            e = s; e.mem_req = 1'b1; e.mem_sel = 1'b1; e.mem_we = 1'b1;
            step("MTO.MEM", e, 1'b0, 7'h23, 1'b0);
        end
        trap_cycles("MTO", 2'd2, 3);
        chk_perf("MTO");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
